io_link_sched: RTL and testbench
================================

# io_link_sched

Half-duplex link scheduler that sequences the TX and RX FIFOs of the I/O device onto a single shared byte link. It pops bytes from the TX FIFO and presents them on the link, and pushes link bytes into the RX FIFO. It arbitrates link direction round-robin with a per-grant burst limit and a programmable turnaround gap. It sits between the FIFO pair (device side) and the physical link adapter (line side).

## Interface
- BURST, 4, max bytes per grant; legal 1..255
- GAP, 2, idle turnaround cycles on direction change; legal 0..15
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  scheduler enable; low blocks new grants
- emptytx  in  1  TX FIFO empty
- rdtx  out  1  TX FIFO read strobe, one cycle per byte
- outdata_tx  in  8  TX FIFO data; valid the cycle after rdtx, held until next rdtx
- fullrx  in  1  RX FIFO full
- wrrx  out  1  RX FIFO write strobe
- indata_rx  out  8  RX FIFO write data
- line_dir  out  1  link direction: 1 = TX, 0 = RX
- tx_valid  out  1  line transmit byte valid
- tx_data  out  8  line transmit byte
- tx_ready  in  1  line adapter accepts tx_data
- rx_req  in  1  peer has bytes to send
- rx_valid  in  1  line receive byte valid
- rx_data  in  8  line receive byte
- rx_ready  out  1  scheduler accepts rx_data
- busy  out  1  state != IDLE
- tx_count  out  16  bytes sent on the line, wraps at 0xFFFF
- rx_count  out  16  bytes written to RX FIFO, wraps at 0xFFFF

## Operation
- Requests: txr = !emptytx; rxr = rx_req & !fullrx. No grant while en = 0.
- States: IDLE, GAP, TX_RD, TX_OUT, RX.
- IDLE: if only one request, grant it. If both, grant the direction opposite last_grant. The granted direction equals line_dir -> go to TX_RD or RX. Otherwise toggle line_dir, load the gap counter with GAP, and go to GAP; with GAP = 0, go straight to TX_RD/RX, with line_dir toggled in the same edge.
- GAP: all strobes low; count down; at 0 go to TX_RD or RX.
- TX_RD: rdtx = 1 for exactly one cycle -> TX_OUT.
- TX_OUT: tx_valid = 1, tx_data = outdata_tx (combinational). On tx_valid & tx_ready: increment burst_cnt and tx_count. Then:
  - burst_cnt = BURST, emptytx = 1 (post-pop value), or en = 0 -> IDLE, last_grant = TX.
  - Otherwise -> TX_RD.
- RX: rx_ready = !fullrx; wrrx = rx_valid & rx_ready; indata_rx = rx_data (combinational). Each write increments burst_cnt and rx_count. Leave to IDLE with last_grant = RX when any of these holds:
  - burst_cnt reaches BURST.
  - No beat this cycle and (rx_req = 0, fullrx = 1, or en = 0).
- burst_cnt (8-bit) clears on every grant.

## Timing
- Reset values: state IDLE, line_dir 0, last_grant RX (TX wins the first tie), rdtx/wrrx/tx_valid/rx_ready/busy 0, counters 0, tx_data/indata_rx follow their combinational sources.
- Reset asserted mid-burst aborts immediately. A byte already popped but not handshaken is discarded.
- TX throughput: 2 cycles per byte minimum (TX_RD + TX_OUT). tx_valid rises 1 cycle after rdtx.
- TX_OUT stall: tx_valid and tx_data are held stable. No further rdtx until the handshake.
- RX throughput: 1 byte per cycle. wrrx is never asserted while fullrx = 1.
- Direction-change overhead is GAP + 1 cycles from the IDLE decision to the first strobe. A same-direction regrant costs 1 IDLE cycle.
- en falling mid-burst: the current TX byte completes its handshake, then IDLE. RX exits at the first non-beat cycle or the burst limit.

## Test plan
- Reset: pulse rst low during TX_OUT -> next cycle tx_valid 0, rdtx 0, line_dir 0, busy 0, tx_count 0.
- TX only, GAP=2, BURST=4: FIFO holds 0xA1,0xA2,0xA3, tx_ready = 1 -> line_dir 1 after IDLE, 2 gap cycles, then 3 rdtx pulses; tx_data A1, A2, A3 on the handshakes; tx_count = 3; IDLE on empty.
- Round robin: TX FIFO holds 10 bytes, rx_req = 1, rx_valid = 1 -> bursts TX4, gap, RX4, gap, TX4, gap, RX4, gap, TX2; rx_count = 8, tx_count = 10.
- RX backpressure: fullrx goes to 1 after 2 RX writes -> rx_ready 0, wrrx 0 that cycle, exit to IDLE; no RX grant while fullrx = 1; rx_count = 2.
- TX stall: tx_ready held low 5 cycles with tx_data = 0x5C -> tx_valid and 0x5C are stable; exactly one rdtx per byte.
- GAP=0, BURST=1, alternating requests -> line_dir toggles each grant with no idle gap cycles; one byte per grant.

Source files
------------

// File: rtl/io_link_sched_if.sv
// io_link_sched_if: FIFO-side and line-side signals of the half-duplex link scheduler.
interface io_link_sched_if;
  logic       emptytx;
  logic       rdtx;
  logic [7:0] outdata_tx;
  logic       fullrx;
  logic       wrrx;
  logic [7:0] indata_rx;
  logic       line_dir;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_req;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  modport master (
    input  emptytx, outdata_tx, fullrx, tx_ready, rx_req, rx_valid, rx_data,
    output rdtx, wrrx, indata_rx, line_dir, tx_valid, tx_data, rx_ready
  );
  modport slave (
    output emptytx, outdata_tx, fullrx, tx_ready, rx_req, rx_valid, rx_data,
    input  rdtx, wrrx, indata_rx, line_dir, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/io_link_sched.sv
// io_link_sched: round-robin, burst-limited scheduler of a TX/RX FIFO pair onto one half-duplex byte link.
module io_link_sched #(
  parameter int BURST = 4,
  parameter int GAP   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  io_link_sched_if.master lk,
  output logic            busy,
  output logic [15:0]     tx_count,
  output logic [15:0]     rx_count
);
  typedef enum logic [2:0] {S_IDLE, S_GAP, S_TX_RD, S_TX_OUT, S_RX} state_t;
  localparam logic [7:0] BURST_L = 8'(BURST);
  localparam logic [3:0] GAP_L   = 4'(GAP);
  state_t      state_q, state_d;
  logic        line_dir_q, line_dir_d;
  logic        last_tx_q, last_tx_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  burst_q, burst_d;
  logic [15:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic        rdtx_q, rdtx_d, tx_valid_q, tx_valid_d, busy_q, busy_d;
  logic        txr, rxr, gtx, beat;
  assign txr          = !lk.emptytx;
  assign rxr          = lk.rx_req & !lk.fullrx;
  assign gtx          = txr & (!rxr | !last_tx_q);
  assign lk.rx_ready  = (state_q == S_RX) & !lk.fullrx;
  assign beat         = lk.rx_ready & lk.rx_valid;
  assign lk.wrrx      = beat;
  assign lk.indata_rx = lk.rx_data;
  assign lk.tx_data   = lk.outdata_tx;
  assign lk.rdtx      = rdtx_q;
  assign lk.tx_valid  = tx_valid_q;
  assign lk.line_dir  = line_dir_q;
  assign busy         = busy_q;
  assign tx_count     = tx_count_q;
  assign rx_count     = rx_count_q;
  always_comb begin
    state_d    = state_q;
    line_dir_d = line_dir_q;
    last_tx_d  = last_tx_q;
    gap_d      = gap_q;
    burst_d    = burst_q;
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    case (state_q)
      S_IDLE: if (en & (txr | rxr)) begin
        burst_d    = '0;
        line_dir_d = gtx;
        if (gtx != line_dir_q && GAP_L != 4'd0) begin
          gap_d   = GAP_L;
          state_d = S_GAP;
        end else state_d = gtx ? S_TX_RD : S_RX;
      end
      S_GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_d == 4'd0) state_d = line_dir_q ? S_TX_RD : S_RX;
      end
      S_TX_RD: state_d = S_TX_OUT;
      S_TX_OUT: if (lk.tx_ready) begin
        burst_d    = burst_q + 8'd1;
        tx_count_d = tx_count_q + 16'd1;
        // emptytx here already reflects the pop issued in TX_RD
        if (burst_d == BURST_L || lk.emptytx || !en) begin
          state_d   = S_IDLE;
          last_tx_d = 1'b1;
        end else state_d = S_TX_RD;
      end
      S_RX: begin
        if (beat) begin
          burst_d    = burst_q + 8'd1;
          rx_count_d = rx_count_q + 16'd1;
        end
        if (beat ? burst_d == BURST_L : (!lk.rx_req | lk.fullrx | !en)) begin
          state_d   = S_IDLE;
          last_tx_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdtx_d     = state_d == S_TX_RD;
    tx_valid_d = state_d == S_TX_OUT;
    busy_d     = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= S_IDLE;
      line_dir_q <= 1'b0;
      last_tx_q  <= 1'b0;
      gap_q      <= '0;
      burst_q    <= '0;
      tx_count_q <= '0;
      rx_count_q <= '0;
      rdtx_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_dir_q <= line_dir_d;
      last_tx_q  <= last_tx_d;
      gap_q      <= gap_d;
      burst_q    <= burst_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      rdtx_q     <= rdtx_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
endmodule

// File: tb/tb_io_link_sched.sv
// tb_io_link_sched: grant-level reference model plus FIFO environment, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_io_link_sched;
  localparam int BURST = 4;
  localparam int GAP   = 2;
  logic clk = 0, rst = 0, en = 0, en1 = 0;
  always #5 clk = ~clk;
  io_link_sched_if lk ();
  io_link_sched_if lk1 ();
  logic busy, busy1;
  logic [15:0] tx_count, rx_count, tx_count1, rx_count1;
  io_link_sched #(.BURST(BURST), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .lk(lk),
    .busy(busy), .tx_count(tx_count), .rx_count(rx_count));
  io_link_sched #(.BURST(1), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .lk(lk1),
    .busy(busy1), .tx_count(tx_count1), .rx_count(rx_count1));

  int total = 0, bad = 0;
  logic [7:0] txq[$];
  logic [7:0] hs[$];
  int rxw, ncyc, nrd, ndir, first_rd;
  bit auto_full;
  // model of the scheduler as grants: idle, gap cycles left, granted direction, read pending, bytes in grant
  bit m_idle, m_gtx, m_rd, m_dir, m_last_tx;
  int m_gap, m_n;
  logic [15:0] m_txc, m_rxc;
  logic [7:0] m_byte;
  logic s_rd, s_v, s_dir, s_busy, s1_dir, s1_rd, s1_v, s1_wr;
  logic [7:0] s_d;
  logic [15:0] s_txc, s_rxc;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    txq.push_back(b);
    lk.emptytx = 1'b0;
  endtask

  task automatic cyc();
    bit txr, rxr, beat, e_data, e_rd, e_v, e_rr, e_wr, rd_seen;
    @(negedge clk);
    if (!rst) begin
      m_idle = 1; m_dir = 0; m_last_tx = 0; m_gap = 0; m_txc = 0; m_rxc = 0; m_rd = 0;
    end
    e_data = !m_idle && m_gap == 0;
    e_rd   = e_data && m_gtx && m_rd;
    e_v    = e_data && m_gtx && !m_rd;
    e_rr   = e_data && !m_gtx && !lk.fullrx;
    e_wr   = e_rr && lk.rx_valid;
    chk("rdtx", lk.rdtx, e_rd);
    chk("tx_valid", lk.tx_valid, e_v);
    chk("rx_ready", lk.rx_ready, e_rr);
    chk("wrrx", lk.wrrx, e_wr);
    chk("line_dir", lk.line_dir, m_dir);
    chk("busy", busy, !m_idle);
    chk("tx_count", tx_count, m_txc);
    chk("rx_count", rx_count, m_rxc);
    if (e_v) chk("tx_data", lk.tx_data, m_byte);
    if (e_wr) chk("indata_rx", lk.indata_rx, lk.rx_data);
    s_rd = lk.rdtx; s_v = lk.tx_valid; s_d = lk.tx_data; s_dir = lk.line_dir; s_busy = busy;
    s_txc = tx_count; s_rxc = rx_count;
    s1_dir = lk1.line_dir; s1_rd = lk1.rdtx; s1_v = lk1.tx_valid; s1_wr = lk1.wrrx;
    if (lk.rdtx) begin
      nrd++;
      if (first_rd < 0) first_rd = ncyc;
    end
    if (rst) begin
      if (m_idle) begin
        txr = !lk.emptytx;
        rxr = lk.rx_req && !lk.fullrx;
        if (en && (txr || rxr)) begin
          m_gtx = txr && (!rxr || !m_last_tx);
          m_idle = 0; m_n = 0; m_rd = m_gtx;
          if (m_gtx != m_dir) begin
            m_dir = m_gtx;
            m_gap = GAP;
          end
        end
      end else if (m_gap > 0) m_gap--;
      else if (m_gtx && m_rd) begin
        m_rd = 0;
        m_byte = txq.size() > 0 ? txq[0] : 8'hxx;
      end else if (m_gtx) begin
        if (lk.tx_ready) begin
          m_n++; m_txc++; hs.push_back(m_byte);
          if (m_n == BURST || lk.emptytx || !en) begin
            m_idle = 1; m_last_tx = 1;
          end else m_rd = 1;
        end
      end else begin
        beat = lk.rx_valid && !lk.fullrx;
        if (beat) begin
          m_n++; m_rxc++;
        end
        if (beat ? m_n == BURST : (!lk.rx_req || lk.fullrx || !en)) begin
          m_idle = 1; m_last_tx = 0;
        end
      end
    end
    rd_seen = lk.rdtx;
    if (lk.wrrx) rxw++;
    @(posedge clk);
    #1;
    if (rd_seen && txq.size() > 0) lk.outdata_tx = txq.pop_front();
    lk.emptytx = txq.size() == 0;
    if (auto_full) lk.fullrx = rxw >= 2;
    if (s_dir != lk.line_dir) ndir++;
    ncyc++;
  endtask

  task automatic do_reset();
    rst = 0; en = 0;
    txq.delete(); hs.delete();
    lk.emptytx = 1; lk.tx_ready = 0; lk.rx_req = 0; lk.rx_valid = 0; lk.fullrx = 0;
    auto_full = 0; rxw = 0;
    cyc();
    rst = 1;
    ncyc = 0; nrd = 0; ndir = 0; first_rd = -1;
  endtask

  initial begin
    lk.outdata_tx = 8'h00; lk.rx_data = 8'h00;
    lk1.emptytx = 0; lk1.outdata_tx = 8'h33; lk1.fullrx = 0; lk1.tx_ready = 1;
    lk1.rx_req = 1; lk1.rx_valid = 1; lk1.rx_data = 8'h44;
    do_reset();
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_dir", s_dir, 1'b0);
    chk("rst_txc", s_txc, 16'd0);

    // TX only: A1, A2, A3 after one IDLE and two gap cycles
    en = 1; lk.tx_ready = 1;
    push(8'hA1); push(8'hA2); push(8'hA3);
    for (int i = 0; i < 20; i++) cyc();
    chk("txo_first_rdtx", first_rd, 3);
    chk("txo_nrd", nrd, 3);
    chk("txo_txc", s_txc, 16'd3);
    chk("txo_dir", s_dir, 1'b1);
    chk("txo_busy", s_busy, 1'b0);
    chk("txo_nhs", hs.size(), 3);
    if (hs.size() == 3) begin
      chk("txo_b0", hs[0], 8'hA1);
      chk("txo_b1", hs[1], 8'hA2);
      chk("txo_b2", hs[2], 8'hA3);
    end

    // round robin: TX4 RX4 TX4 RX4 TX2 with gaps between
    do_reset();
    en = 1; lk.tx_ready = 1; lk.rx_req = 1; lk.rx_valid = 1;
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
    for (int i = 0; i < 300 && m_txc != 16'd10; i++) begin
      lk.rx_data = 8'($urandom);
      cyc();
    end
    lk.rx_req = 0;
    for (int i = 0; i < 10; i++) cyc();
    chk("rr_txc", s_txc, 16'd10);
    chk("rr_rxc", s_rxc, 16'd8);
    chk("rr_dirchg", ndir, 5);

    // RX backpressure: FIFO fills after two writes
    do_reset();
    en = 1; lk.rx_req = 1; lk.rx_valid = 1; auto_full = 1;
    for (int i = 0; i < 20; i++) cyc();
    chk("bp_rxc", s_rxc, 16'd2);
    chk("bp_busy", s_busy, 1'b0);

    // TX stall with 0x5C held for five cycles
    do_reset();
    en = 1;
    push(8'h5C);
    for (int i = 0; i < 4; i++) cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_valid", s_v, 1'b1);
      chk("stall_data", s_d, 8'h5C);
    end
    lk.tx_ready = 1;
    cyc(); cyc();
    chk("stall_txc", s_txc, 16'd1);
    chk("stall_nrd", nrd, 1);

    // reset during TX_OUT
    lk.tx_ready = 0;
    push(8'h11); push(8'h22);
    for (int i = 0; i < 3; i++) cyc();
    chk("pre_rst_valid", s_v, 1'b1);
    rst = 0;
    cyc();
    chk("mid_rst_valid", s_v, 1'b0);
    chk("mid_rst_rdtx", s_rd, 1'b0);
    chk("mid_rst_dir", s_dir, 1'b0);
    chk("mid_rst_busy", s_busy, 1'b0);
    chk("mid_rst_txc", s_txc, 16'd0);

    // GAP=0 / BURST=1 instance: direction toggles every grant, no gap cycles
    rst = 0; en1 = 1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      int p;
      bit ed, er, ev, ew;
      cyc();
      p = (i - 1) % 5;
      ed = i > 0 && p < 3; er = i > 0 && p == 0; ev = i > 0 && p == 1; ew = i > 0 && p == 3;
      chk("g0_dir", s1_dir, ed);
      chk("g0_rdtx", s1_rd, er);
      chk("g0_valid", s1_v, ev);
      chk("g0_wrrx", s1_wr, ew);
    end

    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      en = $urandom_range(0, 15) != 0;
      lk.tx_ready = $urandom_range(0, 3) != 0;
      lk.rx_req = $urandom_range(0, 2) != 0;
      lk.rx_valid = 1'($urandom_range(0, 1));
      lk.fullrx = $urandom_range(0, 7) == 0;
      lk.rx_data = 8'($urandom);
      if ($urandom_range(0, 2) == 0 && txq.size() < 8) push(8'($urandom));
      rst = $urandom_range(0, 599) != 0;
      cyc();
    end
    rst = 1;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
